instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, 32'd0, word-indexed PC loaded at reset.
REQ-002 i_clk  in  1  sole clock, rising edge.
REQ-003 i_rstn  in  1  reset, asynchronous, active-low.
REQ-004 imem_req  out  1  fetch request valid.
REQ-005 imem_addr  out  32  word address of the request, equal to pc_reg.
REQ-006 imem_ready  in  1  memory accepts the request this cycle (req && ready = handshake).
REQ-007 imem_rvalid  in  1  response data valid; at most one per accepted request; never before acceptance.
REQ-008 imem_rdata  in  32  fetched instruction.
REQ-009 i_stall  in  1  decode cannot take a new instruction this cycle.
REQ-010 i_update_pc  in  1  redirect request from decode.
REQ-011 i_new_pc  in  32  redirect target (word index).
REQ-012 instruction_reg  out  32  registered instruction to decode.
REQ-013 current_pc  out  32  registered word PC of instruction_reg.
REQ-014 instr_valid  out  1  instruction_reg/current_pc hold an unconsumed instruction.

Function
REQ-015 PC is word-indexed: sequential increment SHALL be +1 (mod 2^32, wrap 32'hFFFFFFFF -> 0).
REQ-016 States SHALL be S_REQ, S_WAIT, S_HOLD; at most one request outstanding.
REQ-017 S_REQ: imem_req=1, imem_addr=pc_reg; on imem_ready go S_WAIT; imem_req=0 in every other state.
REQ-018 "Slot free" SHALL mean !instr_valid || !i_stall (consumption = instr_valid && !i_stall).
REQ-019 S_WAIT, imem_rvalid, no kill, slot free: instruction_reg<=imem_rdata, current_pc<=pc_reg, instr_valid<=1, pc_reg<=pc_reg+1, go S_REQ.
REQ-020 S_WAIT, imem_rvalid, no kill, slot not free: capture rdata/pc into a one-entry hold register, pc_reg<=pc_reg+1, go S_HOLD.
REQ-021 S_HOLD: when slot free, move hold into output (instr_valid<=1), go S_REQ; no new request while in S_HOLD.
REQ-022 Consumption with no new load SHALL clear instr_valid next cycle.
REQ-023 Latency: with ready in the request cycle and rvalid the next cycle, instr_valid SHALL rise 2 cycles after the request cycle; steady throughput 1 instruction per 2 cycles.
REQ-024 Redirect (i_update_pc=1) SHALL have priority over all other events: pc_reg<=i_new_pc, instr_valid<=0, hold emptied, go S_REQ.
REQ-025 Redirect while a request is outstanding (S_WAIT without rvalid, or S_REQ with imem_ready the same cycle): set kill, stay/go S_WAIT; the next rvalid SHALL be discarded, kill cleared, go S_REQ.
REQ-026 Redirect in S_WAIT with rvalid the same cycle: data discarded, no kill set, go S_REQ.
REQ-027 Redirect in S_REQ without imem_ready: imem_addr SHALL show i_new_pc from the next cycle; the memory must tolerate the address change.
REQ-028 Redirect and i_stall in the same cycle: redirect wins; the flushed instruction is not delivered.

Reset
REQ-029 Asynchronous on i_rstn low: pc_reg=RESET_PC, state=S_REQ, kill=0, hold empty, instr_valid=0, instruction_reg=32'h00000013, current_pc=0.
REQ-030 Reset while a request is outstanding SHALL abandon it; the memory must not return rvalid for it after reset release.
REQ-031 imem_req SHALL assert in the first clock edge-cycle after i_rstn deasserts.

Configuration
REQ-032 Macro IF_BUBBLE_NOP_EN defined: whenever instr_valid=0, instruction_reg SHALL read 32'h00000013 (NOP), current_pc SHALL read 0.
REQ-033 IF_BUBBLE_NOP_EN undefined: instruction_reg and current_pc SHALL hold their last values when instr_valid=0.

Verification
REQ-034 Reset, RESET_PC=0, zero-wait memory returning addr+0x100: instr_valid at cycles 2,4,6 with current_pc 0,1,2 and instruction_reg 0x100,0x101,0x102.
REQ-035 i_stall held 5 cycles while 0x100 valid: output stays 0x100/pc 0; one response held in S_HOLD; after release 0x101/pc 1 appears with no loss or duplicate.
REQ-036 Redirect to 0x40 while rvalid delayed 3 cycles: late response discarded; next delivered instruction has current_pc 0x40.
REQ-037 RESET_PC=32'hFFFFFFFF: second instruction has current_pc 0 (wrap).
REQ-038 Redirect coincident with i_stall and rvalid: instr_valid=0 next cycle, next request address = i_new_pc; with IF_BUBBLE_NOP_EN, instruction_reg=0x00000013 during the bubble.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch: one outstanding imem request, 2-cycle fetch latency, i_stall holds output and parks one response in S_HOLD.
// Optional IF_BUBBLE_NOP_EN: instruction_reg/current_pc read NOP/0 whenever instr_valid is low.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        i_stall,
  input  logic        i_update_pc,
  input  logic [31:0] i_new_pc,
  output logic [31:0] instruction_reg,
  output logic [31:0] current_pc,
  output logic        instr_valid
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  localparam logic [31:0] NOP = 32'h00000013;

  state_t      state, state_nxt;
  logic [31:0] pc_reg, pc_nxt;
  logic [31:0] instr_q, instr_nxt;
  logic [31:0] cpc_q, cpc_nxt;
  logic [31:0] hold_instr, hold_instr_nxt;
  logic [31:0] hold_pc, hold_pc_nxt;
  logic        kill, kill_nxt;
  logic        valid_q, valid_nxt;
  logic        slot_free;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= S_REQ;
      pc_reg     <= RESET_PC;
      instr_q    <= NOP;
      cpc_q      <= '0;
      hold_instr <= '0;
      hold_pc    <= '0;
      kill       <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc_reg     <= pc_nxt;
      instr_q    <= instr_nxt;
      cpc_q      <= cpc_nxt;
      hold_instr <= hold_instr_nxt;
      hold_pc    <= hold_pc_nxt;
      kill       <= kill_nxt;
      valid_q    <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc_reg;
    instr_nxt      = instr_q;
    cpc_nxt        = cpc_q;
    hold_instr_nxt = hold_instr;
    hold_pc_nxt    = hold_pc;
    kill_nxt       = kill;
    valid_nxt      = valid_q && i_stall;
    imem_req       = (state == S_REQ);
    imem_addr      = pc_reg;
    slot_free      = !valid_q || !i_stall;

    if (i_update_pc) begin
      // A redirect with a request still in flight must swallow its response.
      pc_nxt    = i_new_pc;
      valid_nxt = 1'b0;
      state_nxt = S_REQ;
      kill_nxt  = 1'b0;
      if ((state == S_REQ && imem_ready) || (state == S_WAIT && !imem_rvalid)) begin
        kill_nxt  = 1'b1;
        state_nxt = S_WAIT;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ready) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (kill) begin
              kill_nxt  = 1'b0;
              state_nxt = S_REQ;
            end else begin
              pc_nxt = pc_reg + 32'd1;
              if (slot_free) begin
                instr_nxt = imem_rdata;
                cpc_nxt   = pc_reg;
                valid_nxt = 1'b1;
                state_nxt = S_REQ;
              end else begin
                hold_instr_nxt = imem_rdata;
                hold_pc_nxt    = pc_reg;
                state_nxt      = S_HOLD;
              end
            end
          end
        end
        S_HOLD: begin
          if (slot_free) begin
            instr_nxt = hold_instr;
            cpc_nxt   = hold_pc;
            valid_nxt = 1'b1;
            state_nxt = S_REQ;
          end
        end
        default: state_nxt = S_REQ;
      endcase
    end
  end

  assign instr_valid = valid_q;
`ifdef IF_BUBBLE_NOP_EN
  assign instruction_reg = valid_q ? instr_q : NOP;
  assign current_pc      = valid_q ? cpc_q : 32'd0;
`else
  assign instruction_reg = instr_q;
  assign current_pc      = cpc_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected (pc, instr) pairs queued by stimulus, popped on each consumption.
module tb_instruction_fetch;

  logic        i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic        i_rstn, imem_ready, imem_rvalid, i_stall, i_update_pc;
  logic [31:0] imem_rdata, i_new_pc;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instruction_reg, current_pc;

  logic        ready_b, rvalid_b, stall_b, upd_b;
  logic [31:0] rdata_b, newpc_b;
  logic        req_b, valid_b;
  logic [31:0] addr_b, instr_b, cur_b;

  instruction_fetch dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .i_stall(i_stall), .i_update_pc(i_update_pc), .i_new_pc(i_new_pc),
    .instruction_reg(instruction_reg), .current_pc(current_pc), .instr_valid(instr_valid)
  );

  instruction_fetch #(.RESET_PC(32'hFFFFFFFF)) dut_wrap (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .imem_req(req_b), .imem_addr(addr_b), .imem_ready(ready_b),
    .imem_rvalid(rvalid_b), .imem_rdata(rdata_b),
    .i_stall(stall_b), .i_update_pc(upd_b), .i_new_pc(newpc_b),
    .instruction_reg(instr_b), .current_pc(cur_b), .instr_valid(valid_b)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          mem_delay = 0;
  int          cnt = 0;
  logic        hs = 1'b0, pending = 1'b0, hs_b = 1'b0;
  logic [31:0] haddr = '0, paddr = '0, haddr_b = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic next(input int n = 1);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({pc, instr});
  endtask

  task automatic hold_reset();
    i_rstn = 1'b0; imem_ready = 1'b0; i_stall = 1'b0;
    i_update_pc = 1'b0; i_new_pc = '0; mem_delay = 0;
    next(2);
  endtask

  task automatic release_reset();
    i_rstn = 1'b1;
    imem_ready = 1'b1;
  endtask

  // Monitor: handshake capture for the memory models and scoreboard compare on consumption.
  always @(negedge i_clk) begin
    hs      = i_rstn && imem_req && imem_ready;
    haddr   = imem_addr;
    hs_b    = i_rstn && req_b && ready_b;
    haddr_b = addr_b;
    if (i_rstn === 1'b1 && instr_valid === 1'b1 && i_stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pc %h instr %h, expected nothing", current_pc, instruction_reg);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", current_pc, e.pc);
        chk("sb_instr", instruction_reg, e.instr);
      end
    end
  end

  // Memory for dut: returns addr+0x100, mem_delay extra cycles after the acceptance cycle.
  always @(posedge i_clk) begin
    #1;
    imem_rvalid = 1'b0;
    if (i_rstn !== 1'b1) begin
      pending = 1'b0;
    end else begin
      if (hs) begin
        pending = 1'b1;
        paddr   = haddr;
        cnt     = mem_delay;
      end
      if (pending) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = paddr + 32'h100;
          pending     = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  always @(posedge i_clk) begin
    #1;
    rvalid_b = hs_b;
    rdata_b  = haddr_b + 32'h100;
  end

  initial begin
    imem_rvalid = 1'b0; imem_rdata = '0;
    ready_b = 1'b1; rvalid_b = 1'b0; rdata_b = '0;
    stall_b = 1'b0; upd_b = 1'b0; newpc_b = '0;

    // Reset state and zero-wait streaming
    hold_reset();
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instruction_reg, 32'h00000013);
    chk("rst_pc", current_pc, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_addr_wrap", addr_b, 32'hFFFFFFFF);
    release_reset();
    push(32'd0, 32'h100);
    push(32'd1, 32'h101);
    push(32'd2, 32'h102);
    for (int k = 0; k <= 6; k++) begin
      if (k == 0) chk("req_after_rst", imem_req, 1'b1);
      if (k == 6) imem_ready = 1'b0;
      chk($sformatf("lat_valid_c%0d", k), instr_valid, (k == 2 || k == 4 || k == 6));
      if (k == 2) begin
        chk("wrap_pc0", cur_b, 32'hFFFFFFFF);
        chk("wrap_instr0", instr_b, 32'h000000FF);
      end
      if (k == 4) begin
        chk("wrap_pc1", cur_b, 32'd0);
        chk("wrap_instr1", instr_b, 32'h100);
      end
      next();
    end
    next(3);
    chk("stream_drained", exp_q.size(), 0);

    // Stall 5 cycles with one response parked in the hold register
    hold_reset();
    release_reset();
    push(32'd0, 32'h100);
    push(32'd1, 32'h101);
    push(32'd2, 32'h102);
    for (int k = 0; k <= 12; k++) begin
      if (k == 2) i_stall = 1'b1;
      if (k == 7) i_stall = 1'b0;
      if (k == 10) imem_ready = 1'b0;
      if (k == 5) begin
        chk("hold_no_req", imem_req, 1'b0);
        chk("hold_valid", instr_valid, 1'b1);
        chk("hold_out_instr", instruction_reg, 32'h100);
        chk("hold_out_pc", current_pc, 32'd0);
      end
      if (k == 8) begin
        chk("hold_next_req", imem_req, 1'b1);
        chk("hold_next_addr", imem_addr, 32'd2);
      end
      next();
    end
    chk("stall_drained", exp_q.size(), 0);

    // Redirect while a slow response is outstanding
    hold_reset();
    mem_delay = 3;
    release_reset();
    push(32'h40, 32'h140);
    for (int k = 0; k <= 12; k++) begin
      if (k == 1) begin
        i_update_pc = 1'b1;
        i_new_pc    = 32'h40;
      end
      if (k == 2) begin
        i_update_pc = 1'b0;
        chk("kill_wait_req", imem_req, 1'b0);
      end
      if (k == 5) begin
        chk("redir_req", imem_req, 1'b1);
        chk("redir_addr", imem_addr, 32'h40);
        chk("redir_no_late", instr_valid, 1'b0);
      end
      if (k == 6) imem_ready = 1'b0;
      next();
    end
    chk("redir_drained", exp_q.size(), 0);

    // Redirect coincident with stall and rvalid
    hold_reset();
    release_reset();
    push(32'h80, 32'h180);
    for (int k = 0; k <= 8; k++) begin
      if (k == 2) i_stall = 1'b1;
      if (k == 3) begin
        i_update_pc = 1'b1;
        i_new_pc    = 32'h80;
      end
      if (k == 4) begin
        i_update_pc = 1'b0;
        i_stall     = 1'b0;
        chk("bubble_valid", instr_valid, 1'b0);
        chk("bubble_req", imem_req, 1'b1);
        chk("bubble_addr", imem_addr, 32'h80);
`ifdef IF_BUBBLE_NOP_EN
        chk("bubble_instr", instruction_reg, 32'h00000013);
        chk("bubble_pc", current_pc, 32'd0);
`else
        chk("bubble_instr", instruction_reg, 32'h100);
        chk("bubble_pc", current_pc, 32'd0);
`endif
      end
      if (k == 5) imem_ready = 1'b0;
      next();
    end
    chk("final_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
